rng_share_ctrl: RTL

- Controller that sequences the RNG core (`top`: clk, reset, mode[1:0], seed[3:0], output_data[7:0]).
- Owns the core's reset, seed and mode inputs:
  - runs a reset/warm-up sequence after power-up and on each reseed request;
  - then shares the core's 8-bit output between NUM_REQ requesters with round-robin arbitration, one byte per cycle.
- Sits between `tt_um_rng`-level pins and the RNG core.

---
 rtl/rng_share_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rng_share_ctrl.sv
// Purpose: sequences the RNG core (reset, seed, mode) and shares its byte stream round-robin.
// Latency: req sampled at a clock edge -> gnt/gnt_data visible after that edge (1 cycle).
// Backpressure: none; req is a level, an unserved req stays pending until it wins a later cycle.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   seed_in, mode_in    values latched into rng_seed/rng_mode while in RST or on reseed
//   reseed              single-cycle pulse, restarts the reset/warm-up sequence
//   rng_reset           active-high reset to the RNG core (registered)
//   rng_seed, rng_mode  registered seed/mode to the RNG core
//   rng_data            RNG core output, a new byte every cycle
//   req                 level request per requester
//   gnt, gnt_data       registered one-hot grant and the byte granted with it
//   ready               high while serving requests
module rng_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SEED_W  = 4,
    parameter int MODE_W  = 2,
    parameter int RST_CYC = 2,
    parameter int WARMUP  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEED_W-1:0]  seed_in,
    input  logic [MODE_W-1:0]  mode_in,
    input  logic               reseed,
    output logic               rng_reset,
    output logic [SEED_W-1:0]  rng_seed,
    output logic [MODE_W-1:0]  rng_mode,
    input  logic [DATA_W-1:0]  rng_data,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [DATA_W-1:0]  gnt_data,
    output logic               ready
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (RST_CYC > WARMUP) ? RST_CYC : WARMUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_WARM  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [DATA_W-1:0]  gnt_data_nxt;
    logic [SEED_W-1:0]  rng_seed_nxt;
    logic [MODE_W-1:0]  rng_mode_nxt;
    logic               rng_reset_nxt;
    logic               ready_nxt;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. WARM holds for WARMUP counted cycles plus the exit edge,
    // so ready rises RST_CYC + WARMUP + 1 edges after the sequence starts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (reseed) begin
            state_nxt = ST_RST;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_RST: begin
                    if (cnt == CNT_W'(RST_CYC - 1)) begin
                        state_nxt = ST_WARM;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_WARM: begin
                    if (cnt == CNT_W'(WARMUP)) begin
                        state_nxt = ST_SERVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_SERVE;
                end
            endcase
        end
    end

    // Round-robin search: first set req bit at or above ptr, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    // Output logic: next values of all registered outputs
    always_comb begin
        gnt_nxt       = '0;
        gnt_data_nxt  = gnt_data;
        ptr_nxt       = ptr;
        rng_seed_nxt  = rng_seed;
        rng_mode_nxt  = rng_mode;
        rng_reset_nxt = (state_nxt == ST_RST);
        ready_nxt     = (state_nxt == ST_SERVE);
        if (reseed || state == ST_RST) begin
            rng_seed_nxt = seed_in;
            rng_mode_nxt = mode_in;
        end
        // reseed takes priority over any pending request
        if (state == ST_SERVE && !reseed && win_vld) begin
            gnt_nxt      = NUM_REQ'(1) << win_idx;
            gnt_data_nxt = rng_data;
            ptr_nxt      = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_data  <= '0;
            ptr       <= '0;
            rng_seed  <= '0;
            rng_mode  <= '0;
            rng_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_data  <= gnt_data_nxt;
            ptr       <= ptr_nxt;
            rng_seed  <= rng_seed_nxt;
            rng_mode  <= rng_mode_nxt;
            rng_reset <= rng_reset_nxt;
            ready     <= ready_nxt;
        end
    end

endmodule
